// File: rtl/id_ex_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_if
// Description : Bundle between Decode, the M/W forwarding sources and the
//               ID/EX stage. The master drives the Decode slot, stage-control
//               and M/W forwarding signals. The slave (the ID/EX stage) drives
//               the Execute-side operands, control, forwarding selects and the
//               load-use stall request.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    // Stage control and Decode slot
    logic            stall_e;
    logic            flush_e;
    logic            valid_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic [XLEN-1:0] imm_ext_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic [REGW-1:0] rs1_d;
    logic [REGW-1:0] rs2_d;
    logic [REGW-1:0] rd_d;
    logic [2:0]      alu_control_d;
    logic            alu_src_d;
    logic            reg_write_d;
    logic            mem_write_d;
    logic            branch_d;
    logic            jump_d;
    logic [1:0]      result_src_d;
    // Forwarding sources
    logic            reg_write_m;
    logic [REGW-1:0] rd_m;
    logic [XLEN-1:0] alu_result_m;
    logic            reg_write_w;
    logic [REGW-1:0] rd_w;
    logic [XLEN-1:0] result_w;
    // Execute side
    logic            lw_stall;
    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] write_data_e;
    logic [2:0]      alu_control_e;
    logic [REGW-1:0] rd_e;
    logic [REGW-1:0] rs1_e;
    logic [REGW-1:0] rs2_e;
    logic            reg_write_e;
    logic            mem_write_e;
    logic            branch_e;
    logic            jump_e;
    logic [1:0]      result_src_e;
    logic [XLEN-1:0] pc_e;
    logic [XLEN-1:0] pc_plus4_e;
    logic [XLEN-1:0] imm_ext_e;
    logic            valid_e;
    logic [1:0]      forward_a_e;
    logic [1:0]      forward_b_e;

    modport master (
        output stall_e, flush_e, valid_d, rd1_d, rd2_d, imm_ext_d, pc_d,
               pc_plus4_d, rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d,
               reg_write_d, mem_write_d, branch_d, jump_d, result_src_d,
               reg_write_m, rd_m, alu_result_m, reg_write_w, rd_w, result_w,
        input  lw_stall, src_a_e, src_b_e, write_data_e, alu_control_e, rd_e,
               rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e, jump_e,
               result_src_e, pc_e, pc_plus4_e, imm_ext_e, valid_e,
               forward_a_e, forward_b_e
    );

    modport slave (
        input  stall_e, flush_e, valid_d, rd1_d, rd2_d, imm_ext_d, pc_d,
               pc_plus4_d, rs1_d, rs2_d, rd_d, alu_control_d, alu_src_d,
               reg_write_d, mem_write_d, branch_d, jump_d, result_src_d,
               reg_write_m, rd_m, alu_result_m, reg_write_w, rd_w, result_w,
        output lw_stall, src_a_e, src_b_e, write_data_e, alu_control_e, rd_e,
               rs1_e, rs2_e, reg_write_e, mem_write_e, branch_e, jump_e,
               result_src_e, pc_e, pc_plus4_e, imm_ext_e, valid_e,
               forward_a_e, forward_b_e
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with M/W operand forwarding and
//               load-use hazard detection for the 5-stage RV32I core.
// Ports       : clk - rising-edge clock
//               rst - asynchronous, active-low reset
//               bus - id_ex_if.slave. Takes the Decode slot, stall/flush and
//                     M/W forwarding sources. Returns the ALU operands,
//                     registered E-stage control, forwarding selects and
//                     lw_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    id_ex_if.slave    bus
);

    localparam logic [1:0] c_FWD_REG  = 2'b00;
    localparam logic [1:0] c_FWD_W    = 2'b01;
    localparam logic [1:0] c_FWD_M    = 2'b10;
    localparam logic [1:0] c_RES_LOAD = 2'b01;

    // All E-stage state is held in one record, so that a bubble is just '0.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } e_regs_t;

    e_regs_t         r_e;
    e_regs_t         w_load;
    e_regs_t         w_next;
    logic            w_lw_stall;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_wdata;

    // Decode values to load. Side-effecting control is gated by valid_d so that
    // an empty Decode slot can never write or redirect.
    always_comb begin
        w_load             = '0;
        w_load.valid       = bus.valid_d;
        w_load.reg_write   = bus.reg_write_d & bus.valid_d;
        w_load.mem_write   = bus.mem_write_d & bus.valid_d;
        w_load.branch      = bus.branch_d    & bus.valid_d;
        w_load.jump        = bus.jump_d      & bus.valid_d;
        w_load.result_src  = bus.result_src_d;
        w_load.alu_control = bus.alu_control_d;
        w_load.alu_src     = bus.alu_src_d;
        w_load.rd1         = bus.rd1_d;
        w_load.rd2         = bus.rd2_d;
        w_load.imm_ext     = bus.imm_ext_d;
        w_load.pc          = bus.pc_d;
        w_load.pc_plus4    = bus.pc_plus4_d;
        w_load.rs1         = bus.rs1_d;
        w_load.rs2         = bus.rs2_d;
        w_load.rd          = bus.rd_d;
    end

    // A load in E whose destination is read by the instruction in Decode.
    // The bubble inserted below clears valid_e, so this is a one-cycle pulse.
    always_comb begin
        w_lw_stall = r_e.valid & (r_e.result_src == c_RES_LOAD) &
                     (r_e.rd != '0) & bus.valid_d &
                     ((r_e.rd == bus.rs1_d) | (r_e.rd == bus.rs2_d));
    end

    // Update priority: flush, then stall (hold), then load-use bubble, then load.
    always_comb begin
        w_next = w_load;
        if (bus.flush_e) begin
            w_next = '0;
        end else if (bus.stall_e) begin
            w_next = r_e;
        end else if (w_lw_stall) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e <= '0;
        end else begin
            r_e <= w_next;
        end
    end

    // Forwarding selects. M is younger than W, so it wins when both match.
    // x0 is never forwarded.
    always_comb begin
        w_fwd_a = c_FWD_REG;
        if (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == r_e.rs1)) begin
            w_fwd_a = c_FWD_M;
        end else if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == r_e.rs1)) begin
            w_fwd_a = c_FWD_W;
        end
    end

    always_comb begin
        w_fwd_b = c_FWD_REG;
        if (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == r_e.rs2)) begin
            w_fwd_b = c_FWD_M;
        end else if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == r_e.rs2)) begin
            w_fwd_b = c_FWD_W;
        end
    end

    always_comb begin
        case (w_fwd_a)
            c_FWD_M: w_src_a = bus.alu_result_m;
            c_FWD_W: w_src_a = bus.result_w;
            default: w_src_a = r_e.rd1;
        endcase
        case (w_fwd_b)
            c_FWD_M: w_wdata = bus.alu_result_m;
            c_FWD_W: w_wdata = bus.result_w;
            default: w_wdata = r_e.rd2;
        endcase
    end

    assign bus.lw_stall      = w_lw_stall;
    assign bus.src_a_e       = w_src_a;
    assign bus.write_data_e  = w_wdata;
    assign bus.src_b_e       = r_e.alu_src ? r_e.imm_ext : w_wdata;
    assign bus.forward_a_e   = w_fwd_a;
    assign bus.forward_b_e   = w_fwd_b;
    assign bus.alu_control_e = r_e.alu_control;
    assign bus.rd_e          = r_e.rd;
    assign bus.rs1_e         = r_e.rs1;
    assign bus.rs2_e         = r_e.rs2;
    assign bus.reg_write_e   = r_e.reg_write;
    assign bus.mem_write_e   = r_e.mem_write;
    assign bus.branch_e      = r_e.branch;
    assign bus.jump_e        = r_e.jump;
    assign bus.result_src_e  = r_e.result_src;
    assign bus.pc_e          = r_e.pc;
    assign bus.pc_plus4_e    = r_e.pc_plus4;
    assign bus.imm_ext_e     = r_e.imm_ext;
    assign bus.valid_e       = r_e.valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. It applies a table of
//               directed Decode/forwarding vectors, then runs hand sequences
//               for reset, load-use, flush/stall priority and stall hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    id_ex_if #(.XLEN(32), .REGW(5)) ifc ();

    id_ex_stage #(.XLEN(32), .REGW(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        alu_src;
        logic [31:0] imm;
        logic        valid;
        logic        rwm;
        logic [4:0]  rdm;
        logic [31:0] alum;
        logic        rww;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ewd;
        logic [1:0]  efa;
        logic [1:0]  efb;
        logic        ev;
        logic        erw;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.stall_e = 0; ifc.flush_e = 0; ifc.valid_d = 0;
        ifc.rd1_d = 0; ifc.rd2_d = 0; ifc.imm_ext_d = 0; ifc.pc_d = 0; ifc.pc_plus4_d = 0;
        ifc.rs1_d = 0; ifc.rs2_d = 0; ifc.rd_d = 0; ifc.alu_control_d = 0; ifc.alu_src_d = 0;
        ifc.reg_write_d = 0; ifc.mem_write_d = 0; ifc.branch_d = 0; ifc.jump_d = 0;
        ifc.result_src_d = 0;
        ifc.reg_write_m = 0; ifc.rd_m = 0; ifc.alu_result_m = 0;
        ifc.reg_write_w = 0; ifc.rd_w = 0; ifc.result_w = 0;
    endtask

    task automatic load_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rd1, input logic [1:0] rsrc);
        ifc.valid_d = 1; ifc.reg_write_d = 1;
        ifc.rs1_d = rs1; ifc.rs2_d = rs2; ifc.rd_d = rd;
        ifc.rd1_d = rd1; ifc.rd2_d = 32'h0; ifc.result_src_d = rsrc;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //                rs1 rs2 rd1         rd2         as imm            v  rwm rdm alum          rww rdw resw          ea            eb            ewd           fa     fb     ev erw
        vec[0] = '{5'd1,  5'd2,  32'd5,      32'd7,      1'b0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     32'd5,      32'd7,        32'd7,      2'b00, 2'b00, 1'b1, 1'b1};
        vec[1] = '{5'd3,  5'd6,  32'h11,     32'h22,     1'b0, 32'h0,        1'b1, 1'b1, 5'd3,  32'h1234,  1'b1, 5'd3,  32'h9,     32'h1234,   32'h22,       32'h22,     2'b10, 2'b00, 1'b1, 1'b1};
        vec[2] = '{5'd1,  5'd4,  32'h1,      32'h2,      1'b0, 32'h0,        1'b1, 1'b0, 5'd4,  32'h55,    1'b1, 5'd4,  32'hAA,    32'h1,      32'hAA,       32'hAA,     2'b00, 2'b01, 1'b1, 1'b1};
        vec[3] = '{5'd0,  5'd0,  32'h0,      32'h0,      1'b0, 32'h0,        1'b1, 1'b1, 5'd0,  32'hCC,    1'b1, 5'd0,  32'hBB,    32'h0,      32'h0,        32'h0,      2'b00, 2'b00, 1'b1, 1'b1};
        vec[4] = '{5'd8,  5'd7,  32'h33,     32'h11,     1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     32'h33,     32'hFFFFFFF0, 32'h11,     2'b00, 2'b00, 1'b1, 1'b1};
        vec[5] = '{5'd9,  5'd10, 32'h44,     32'h55,     1'b0, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  32'h0,     32'h44,     32'h55,       32'h55,     2'b00, 2'b00, 1'b0, 1'b0};
        vec[6] = '{5'd12, 5'd13, 32'h1,      32'h2,      1'b0, 32'h0,        1'b1, 1'b1, 5'd13, 32'h777,   1'b1, 5'd12, 32'h888,   32'h888,    32'h777,      32'h777,    2'b01, 2'b10, 1'b1, 1'b1};
        vec[7] = '{5'd14, 5'd15, 32'h99,     32'h66,     1'b1, 32'h5,        1'b1, 1'b0, 5'd14, 32'hDEAD,  1'b1, 5'd15, 32'hBEEF,  32'h99,     32'h5,        32'hBEEF,   2'b00, 2'b01, 1'b1, 1'b1};

        // ---------------- Reset with random inputs ----------------
        rst = 1'b0;
        clear_inputs();
        ifc.rd1_d = $urandom; ifc.rd2_d = $urandom; ifc.imm_ext_d = $urandom;
        ifc.pc_d = $urandom; ifc.rs1_d = 5'($urandom); ifc.rs2_d = 5'($urandom);
        ifc.rd_d = 5'($urandom); ifc.valid_d = 1; ifc.reg_write_d = 1; ifc.alu_src_d = 1;
        ifc.result_src_d = 2'b01; ifc.reg_write_m = 1; ifc.rd_m = 5'($urandom);
        ifc.alu_result_m = $urandom; ifc.reg_write_w = 1; ifc.rd_w = 5'($urandom);
        ifc.result_w = $urandom;
        step(); step();
        check("rst_valid_e", 32'(ifc.valid_e), 0);
        check("rst_reg_write_e", 32'(ifc.reg_write_e), 0);
        check("rst_src_a_e", ifc.src_a_e, 0);
        check("rst_src_b_e", ifc.src_b_e, 0);
        check("rst_lw_stall", 32'(ifc.lw_stall), 0);
        check("rst_fwd_a", 32'(ifc.forward_a_e), 0);
        check("rst_fwd_b", 32'(ifc.forward_b_e), 0);
        check("rst_pc_e", ifc.pc_e, 0);
        check("rst_rd_e", 32'(ifc.rd_e), 0);
        clear_inputs();
        rst = 1'b1;

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            ifc.rs1_d = vec[i].rs1; ifc.rs2_d = vec[i].rs2;
            ifc.rd1_d = vec[i].rd1; ifc.rd2_d = vec[i].rd2;
            ifc.alu_src_d = vec[i].alu_src; ifc.imm_ext_d = vec[i].imm;
            ifc.valid_d = vec[i].valid;
            ifc.reg_write_d = 1; ifc.mem_write_d = 1; ifc.branch_d = 1; ifc.jump_d = 1;
            ifc.result_src_d = 2'b10;
            ifc.alu_control_d = 3'(i);
            ifc.rd_d = 5'(i + 16);
            ifc.pc_d = 32'h100 + 32'(4 * i);
            ifc.pc_plus4_d = 32'h104 + 32'(4 * i);
            ifc.reg_write_m = vec[i].rwm; ifc.rd_m = vec[i].rdm; ifc.alu_result_m = vec[i].alum;
            ifc.reg_write_w = vec[i].rww; ifc.rd_w = vec[i].rdw; ifc.result_w = vec[i].resw;
            step();
            check($sformatf("v%0d_src_a", i), ifc.src_a_e, vec[i].ea);
            check($sformatf("v%0d_src_b", i), ifc.src_b_e, vec[i].eb);
            check($sformatf("v%0d_wdata", i), ifc.write_data_e, vec[i].ewd);
            check($sformatf("v%0d_fwd_a", i), 32'(ifc.forward_a_e), 32'(vec[i].efa));
            check($sformatf("v%0d_fwd_b", i), 32'(ifc.forward_b_e), 32'(vec[i].efb));
            check($sformatf("v%0d_valid", i), 32'(ifc.valid_e), 32'(vec[i].ev));
            check($sformatf("v%0d_reg_write", i), 32'(ifc.reg_write_e), 32'(vec[i].erw));
            check($sformatf("v%0d_mem_write", i), 32'(ifc.mem_write_e), 32'(vec[i].erw));
            check($sformatf("v%0d_branch", i), 32'(ifc.branch_e), 32'(vec[i].erw));
            check($sformatf("v%0d_jump", i), 32'(ifc.jump_e), 32'(vec[i].erw));
            check($sformatf("v%0d_alu_ctl", i), 32'(ifc.alu_control_e), 32'(i[2:0]));
            check($sformatf("v%0d_rd", i), 32'(ifc.rd_e), 32'(i + 16));
            check($sformatf("v%0d_pc", i), ifc.pc_e, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d_pc4", i), ifc.pc_plus4_e, 32'h104 + 32'(4 * i));
            check($sformatf("v%0d_imm", i), ifc.imm_ext_e, vec[i].imm);
            check($sformatf("v%0d_rsrc", i), 32'(ifc.result_src_e), 32'h2);
        end

        // ---------------- Load-use on rs1 ----------------
        clear_inputs();
        load_d(5'd1, 5'd2, 5'd5, 32'h10, 2'b01);   // lw x5
        step();
        load_d(5'd5, 5'd6, 5'd7, 32'h20, 2'b00);   // add x7, x5, x6
        #1;
        check("lu_stall_on", 32'(ifc.lw_stall), 1);
        step();
        check("lu_bubble_valid", 32'(ifc.valid_e), 0);
        check("lu_bubble_rw", 32'(ifc.reg_write_e), 0);
        check("lu_stall_off", 32'(ifc.lw_stall), 0);
        step();
        check("lu_add_valid", 32'(ifc.valid_e), 1);
        check("lu_add_rs1", 32'(ifc.rs1_e), 5);
        check("lu_add_src_a", ifc.src_a_e, 32'h20);
        check("lu_add_nostall", 32'(ifc.lw_stall), 0);

        // ---------------- Load-use on rs2, and rd=x0 never stalls ----------------
        load_d(5'd1, 5'd2, 5'd9, 32'h0, 2'b01);    // lw x9
        step();
        load_d(5'd3, 5'd9, 5'd7, 32'h0, 2'b00);
        #1;
        check("lu_rs2_stall", 32'(ifc.lw_stall), 1);
        step();
        load_d(5'd1, 5'd2, 5'd0, 32'h0, 2'b01);    // lw x0
        step();
        load_d(5'd0, 5'd0, 5'd7, 32'h0, 2'b00);
        #1;
        check("lu_x0_nostall", 32'(ifc.lw_stall), 0);
        load_d(5'd3, 5'd4, 5'd7, 32'h0, 2'b00);
        ifc.valid_d = 0;
        ifc.rs1_d = 5'd0;
        #1;
        check("lu_x0_invalid_d", 32'(ifc.lw_stall), 0);

        // ---------------- Flush beats stall ----------------
        clear_inputs();
        load_d(5'd1, 5'd2, 5'd3, 32'h77, 2'b00);
        step();
        ifc.flush_e = 1; ifc.stall_e = 1;
        step();
        check("flush_valid", 32'(ifc.valid_e), 0);
        check("flush_src_a", ifc.src_a_e, 0);
        check("flush_rd", 32'(ifc.rd_e), 0);

        // ---------------- Stall holds for 3 cycles ----------------
        clear_inputs();
        load_d(5'd11, 5'd2, 5'd3, 32'hABC, 2'b00);
        ifc.pc_d = 32'h400;
        step();
        ifc.stall_e = 1;
        load_d(5'd20, 5'd21, 5'd22, 32'h123, 2'b00);
        ifc.pc_d = 32'h800;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d_valid", c), 32'(ifc.valid_e), 1);
            check($sformatf("stall%0d_src_a", c), ifc.src_a_e, 32'hABC);
            check($sformatf("stall%0d_pc", c), ifc.pc_e, 32'h400);
            check($sformatf("stall%0d_rd", c), 32'(ifc.rd_e), 3);
        end
        // Forwarding still tracks M while held.
        ifc.reg_write_m = 1; ifc.rd_m = 5'd11; ifc.alu_result_m = 32'h5A5A;
        #1;
        check("stall_fwd_sel", 32'(ifc.forward_a_e), 2);
        check("stall_fwd_val", ifc.src_a_e, 32'h5A5A);

        // ---------------- Asynchronous reset mid-instruction ----------------
        ifc.stall_e = 0;
        step();
        check("pre_rst_valid", 32'(ifc.valid_e), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifc.valid_e), 0);
        check("async_rst_rd", 32'(ifc.rd_e), 0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
